// File: rtl/mrd_pkg.sv
// Shared definitions for the mixed-radix DFT input stage: the bank count, the
// sample type, the controller states and the size-index to point-count ROM.
package mrd_pkg;

   localparam int SAMPLE_W = 18;
   localparam int BANK_AW  = 8;
   localparam int NBANK    = 5;
   localparam int PTS_W    = 12;
   localparam int NSIZE    = 34;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Frame length for each size index: 12*M with M built from factors 2,3,5
   localparam logic [PTS_W-1:0] SIZE_ROM [0:NSIZE-1] = '{
      12'd12,   12'd24,   12'd36,   12'd48,   12'd60,
      12'd72,   12'd96,   12'd108,  12'd120,  12'd144,
      12'd180,  12'd192,  12'd216,  12'd240,  12'd288,
      12'd300,  12'd324,  12'd360,  12'd384,  12'd432,
      12'd480,  12'd540,  12'd576,  12'd600,  12'd648,
      12'd720,  12'd768,  12'd864,  12'd900,  12'd960,
      12'd972,  12'd1080, 12'd1152, 12'd1200
   };

   function automatic logic size_legal(input logic [5:0] idx);
      return (idx < 6'd34);
   endfunction

   // Illegal indices map to zero points; callers gate on size_legal
   function automatic logic [PTS_W-1:0] size_to_dftpts(input logic [5:0] idx);
      logic [PTS_W-1:0] pts;
      pts = 12'd0;
      if (idx < 6'd34) begin
         pts = SIZE_ROM[idx];
      end else begin
         pts = 12'd0;
      end
      return pts;
   endfunction

endpackage

// File: rtl/mrd_bank_addr_gen.sv
// Bank / address counter pair: bank = n mod 5, address = n div 5.
// A clear together with an increment lands on sample 1 (bank 1, address 0),
// which is what a frame start that writes sample 0 in the same cycle needs.
module mrd_bank_addr_gen
   import mrd_pkg::*;
#(
   parameter int AW = BANK_AW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic [2:0]    o_bank,
   output logic [AW-1:0] o_addr
);

   logic [2:0]    r_bank;
   logic [AW-1:0] r_addr;

   // Step the bank 0..4 and advance the address each time the bank wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bank <= 3'd0;
         r_addr <= '0;
      end else if (i_clr) begin
         r_bank <= i_inc ? 3'd1 : 3'd0;
         r_addr <= '0;
      end else if (i_inc) begin
         if (r_bank == 3'(NBANK - 1)) begin
            r_bank <= 3'd0;
            r_addr <= r_addr + {{(AW-1){1'b0}}, 1'b1};
         end else begin
            r_bank <= r_bank + 3'd1;
         end
      end else begin
         r_bank <= r_bank;
         r_addr <= r_addr;
      end
   end

   assign o_bank = r_bank;
   assign o_addr = r_addr;

endmodule

// File: rtl/mrd_sink_wr.sv
// Input stage of the mixed-radix DFT. Stores one streamed frame into the
// 5-bank data memory (sample n -> bank n mod 5, address n div 5), announces it
// with frame_rdy and refuses further input until the engine pulses proc_done.
// Optional framing check (sop/eop consistency, frm_err port): MRD_SINK_FRMCHK_EN.
module mrd_sink_wr
   import mrd_pkg::*;
#(
   parameter int DW = SAMPLE_W,
   parameter int AW = BANK_AW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          sink_valid,
   input  logic          sink_sop,
   input  logic          sink_eop,
   input  logic [DW-1:0] sink_real,
   input  logic [DW-1:0] sink_imag,
   input  logic [5:0]    sink_size,
   output logic          sink_ready,
   output logic          wr_en,
   output logic [2:0]    wr_bank,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_real,
   output logic [DW-1:0] wr_imag,
   output logic          frame_rdy,
   output logic [11:0]   frame_dftpts,
   output logic [5:0]    frame_size,
   input  logic          proc_done
`ifdef MRD_SINK_FRMCHK_EN
   ,
   output logic          frm_err
`endif
);

   state_t        r_state;
   logic          r_sink_ready;
   logic          r_wr_en;
   logic [2:0]    r_wr_bank;
   logic [AW-1:0] r_wr_addr;
   logic [DW-1:0] r_wr_real;
   logic [DW-1:0] r_wr_imag;
   logic          r_frame_rdy;
   logic [11:0]   r_dftpts;
   logic [5:0]    r_size;
   logic [11:0]   r_n;

   state_t        w_next;
   logic          w_acc;
   logic          w_legal;
   logic [11:0]   w_pts;
   logic          w_last;
   logic          w_wr;
   logic          w_clr;
   logic          w_start;
   logic          w_done;
   logic [2:0]    w_gen_bank;
   logic [AW-1:0] w_gen_addr;
   logic [2:0]    w_wbank;
   logic [AW-1:0] w_waddr;

`ifdef MRD_SINK_FRMCHK_EN
   logic          r_frm_err;
   logic          w_err;
`else
   logic          w_unused_eop;
   assign w_unused_eop = sink_eop;
`endif

   assign w_acc   = sink_valid & r_sink_ready;
   assign w_legal = size_legal(sink_size);
   assign w_pts   = size_to_dftpts(sink_size);
   assign w_last  = (r_n == (r_dftpts - 12'd1));

   mrd_bank_addr_gen #(.AW(AW)) u_bank_addr (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_inc  (w_wr),
      .o_bank (w_gen_bank),
      .o_addr (w_gen_addr)
   );

   // A write that also clears the counters is sample 0 of a new frame
   assign w_wbank = w_clr ? 3'd0 : w_gen_bank;
   assign w_waddr = w_clr ? '0   : w_gen_addr;

   // Decode the accepted sample against the current state
   always_comb begin
      w_next  = r_state;
      w_wr    = 1'b0;
      w_clr   = 1'b0;
      w_start = 1'b0;
      w_done  = 1'b0;
`ifdef MRD_SINK_FRMCHK_EN
      w_err   = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            w_clr = 1'b1;
`ifdef MRD_SINK_FRMCHK_EN
            // sop with eop would be a one-point frame, which no size allows
            if (w_acc && sink_sop && sink_eop) begin
               w_err = 1'b1;
            end else if (w_acc && sink_sop && w_legal) begin
               w_start = 1'b1;
               w_wr    = 1'b1;
               w_next  = ST_FILL;
            end else begin
               w_next  = ST_IDLE;
            end
`else
            if (w_acc && sink_sop && w_legal) begin
               w_start = 1'b1;
               w_wr    = 1'b1;
               w_next  = ST_FILL;
            end else begin
               w_next  = ST_IDLE;
            end
`endif
         end
         ST_FILL: begin
`ifdef MRD_SINK_FRMCHK_EN
            if (w_acc && sink_sop) begin
               // Mid-frame sop drops the partial frame and restarts at n=0
               w_err = 1'b1;
               w_clr = 1'b1;
               if (w_legal && !sink_eop) begin
                  w_start = 1'b1;
                  w_wr    = 1'b1;
               end else begin
                  w_next  = ST_IDLE;
               end
            end else if (w_acc && sink_eop && !w_last) begin
               w_err  = 1'b1;
               w_clr  = 1'b1;
               w_next = ST_IDLE;
            end else if (w_acc) begin
               w_wr = 1'b1;
               if (w_last) begin
                  w_done = 1'b1;
                  w_err  = !sink_eop;
                  w_next = ST_WAIT;
               end else begin
                  w_next = ST_FILL;
               end
            end else begin
               w_next = ST_FILL;
            end
`else
            if (w_acc) begin
               w_wr = 1'b1;
               if (w_last) begin
                  w_done = 1'b1;
                  w_next = ST_WAIT;
               end else begin
                  w_next = ST_FILL;
               end
            end else begin
               w_next = ST_FILL;
            end
`endif
         end
         ST_WAIT: begin
            w_clr = 1'b1;
            if (proc_done) begin
               w_next = ST_IDLE;
            end else begin
               w_next = ST_WAIT;
            end
         end
         default: begin
            w_clr  = 1'b1;
            w_next = ST_IDLE;
         end
      endcase
   end

   // Controller state, frame bookkeeping and registered write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_sink_ready <= 1'b1;
         r_wr_en      <= 1'b0;
         r_wr_bank    <= 3'd0;
         r_wr_addr    <= '0;
         r_wr_real    <= '0;
         r_wr_imag    <= '0;
         r_frame_rdy  <= 1'b0;
         r_dftpts     <= 12'd0;
         r_size       <= 6'd0;
         r_n          <= 12'd0;
`ifdef MRD_SINK_FRMCHK_EN
         r_frm_err    <= 1'b0;
`endif
      end else begin
         r_state      <= w_next;
         r_sink_ready <= (w_next != ST_WAIT);
         r_wr_en      <= w_wr;
         r_frame_rdy  <= w_done;
`ifdef MRD_SINK_FRMCHK_EN
         r_frm_err    <= w_err;
`endif
         if (w_wr) begin
            r_wr_bank <= w_wbank;
            r_wr_addr <= w_waddr;
            r_wr_real <= sink_real;
            r_wr_imag <= sink_imag;
         end else begin
            r_wr_bank <= r_wr_bank;
            r_wr_addr <= r_wr_addr;
            r_wr_real <= r_wr_real;
            r_wr_imag <= r_wr_imag;
         end
         if (w_start) begin
            r_dftpts <= w_pts;
            r_size   <= sink_size;
         end else begin
            r_dftpts <= r_dftpts;
            r_size   <= r_size;
         end
         if (w_clr) begin
            r_n <= w_wr ? 12'd1 : 12'd0;
         end else if (w_wr) begin
            r_n <= r_n + 12'd1;
         end else begin
            r_n <= r_n;
         end
      end
   end

   assign sink_ready   = r_sink_ready;
   assign wr_en        = r_wr_en;
   assign wr_bank      = r_wr_bank;
   assign wr_addr      = r_wr_addr;
   assign wr_real      = r_wr_real;
   assign wr_imag      = r_wr_imag;
   assign frame_rdy    = r_frame_rdy;
   assign frame_dftpts = r_dftpts;
   assign frame_size   = r_size;
`ifdef MRD_SINK_FRMCHK_EN
   assign frm_err      = r_frm_err;
`endif

endmodule

// File: tb/tb_mrd_sink_wr.sv
// Scoreboard bench for mrd_sink_wr: expected writes (bank = n mod 5,
// address = n div 5, data, last flag) are queued as samples are driven and
// popped when the design issues wr_en. Framing cases need MRD_SINK_FRMCHK_EN.
module tb_mrd_sink_wr;

   typedef struct packed {
      logic [2:0]  bank;
      logic [7:0]  addr;
      logic [17:0] re;
      logic [17:0] im;
      logic        last;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        sink_valid;
   logic        sink_sop;
   logic        sink_eop;
   logic [17:0] sink_real;
   logic [17:0] sink_imag;
   logic [5:0]  sink_size;
   logic        sink_ready;
   logic        wr_en;
   logic [2:0]  wr_bank;
   logic [7:0]  wr_addr;
   logic [17:0] wr_real;
   logic [17:0] wr_imag;
   logic        frame_rdy;
   logic [11:0] frame_dftpts;
   logic [5:0]  frame_size;
   logic        proc_done;
`ifdef MRD_SINK_FRMCHK_EN
   logic        frm_err;
`endif

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_chk   = 0;
   int  n_fail  = 0;
   int  rdy_cnt = 0;
   int  exp_rdy = 0;
   int  err_cnt = 0;
   int  exp_err = 0;

   mrd_sink_wr dut (
      .clk          (clk),
      .rst          (rst),
      .sink_valid   (sink_valid),
      .sink_sop     (sink_sop),
      .sink_eop     (sink_eop),
      .sink_real    (sink_real),
      .sink_imag    (sink_imag),
      .sink_size    (sink_size),
      .sink_ready   (sink_ready),
      .wr_en        (wr_en),
      .wr_bank      (wr_bank),
      .wr_addr      (wr_addr),
      .wr_real      (wr_real),
      .wr_imag      (wr_imag),
      .frame_rdy    (frame_rdy),
      .frame_dftpts (frame_dftpts),
      .frame_size   (frame_size),
      .proc_done    (proc_done)
`ifdef MRD_SINK_FRMCHK_EN
      ,
      .frm_err      (frm_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required end of test");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", tag, got, exp);
      end
   endtask

   // Compare every issued write against the head of the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               chk("wr_unexpected", {31'd0, wr_en}, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_bank", {29'd0, wr_bank}, {29'd0, mon_e.bank});
               chk("wr_addr", {24'd0, wr_addr}, {24'd0, mon_e.addr});
               chk("wr_real", {14'd0, wr_real}, {14'd0, mon_e.re});
               chk("wr_imag", {14'd0, wr_imag}, {14'd0, mon_e.im});
               chk("frame_rdy_at_wr", {31'd0, frame_rdy}, {31'd0, mon_e.last});
            end
         end else if (frame_rdy) begin
            chk("frame_rdy_no_wr", {31'd0, frame_rdy}, 32'd0);
         end
         if (frame_rdy) rdy_cnt++;
`ifdef MRD_SINK_FRMCHK_EN
         if (frm_err) err_cnt++;
`endif
      end
   end

   task automatic cyc(input logic v, input logic sop, input logic eop, input logic [5:0] sz,
                      input logic [17:0] re, input logic [17:0] im);
      sink_valid = v;
      sink_sop   = sop;
      sink_eop   = eop;
      sink_size  = sz;
      sink_real  = re;
      sink_imag  = im;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0, 6'd0, 18'd0, 18'd0);
   endtask

   task automatic push_exp(input int n, input logic [17:0] re, input logic [17:0] im, input logic last);
      wr_t e;
      e.bank = 3'(n % 5);
      e.addr = 8'(n / 5);
      e.re   = re;
      e.im   = im;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic frame(input logic [5:0] sz, input int npts, input bit gaps);
      logic [17:0] re;
      logic [17:0] im;
      for (int n = 0; n < npts; n++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) idle(1);
         end
         re = 18'($urandom);
         im = 18'($urandom);
         push_exp(n, re, im, n == npts - 1);
         cyc(1'b1, n == 0, n == npts - 1, sz, re, im);
      end
   endtask

   // Partial frame: n samples, all written but never completed here
   task automatic partial(input logic [5:0] sz, input int nsmp);
      logic [17:0] re;
      logic [17:0] im;
      for (int n = 0; n < nsmp; n++) begin
         re = 18'($urandom);
         im = 18'($urandom);
         push_exp(n, re, im, 1'b0);
         cyc(1'b1, n == 0, 1'b0, sz, re, im);
      end
   endtask

   task automatic end_frame(input int pts, input int sz);
      chk("ready_drop", {31'd0, sink_ready}, 32'd0);
      idle(1);
      exp_rdy++;
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("rdy_count", rdy_cnt, exp_rdy);
      chk("frame_dftpts", {20'd0, frame_dftpts}, pts);
      chk("frame_size", {26'd0, frame_size}, sz);
      chk("err_count", err_cnt, exp_err);
   endtask

   task automatic release_mem();
      idle(2);
      chk("ready_in_wait", {31'd0, sink_ready}, 32'd0);
      proc_done = 1'b1;
      @(posedge clk);
      #1;
      proc_done = 1'b0;
      chk("ready_after_done", {31'd0, sink_ready}, 32'd1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", {31'd0, sink_ready}, 32'd1);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_bank", {29'd0, wr_bank}, 32'd0);
      chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
      chk("rst_wr_real", {14'd0, wr_real}, 32'd0);
      chk("rst_frame_rdy", {31'd0, frame_rdy}, 32'd0);
      chk("rst_dftpts", {20'd0, frame_dftpts}, 32'd0);
      chk("rst_size", {26'd0, frame_size}, 32'd0);
`ifdef MRD_SINK_FRMCHK_EN
      chk("rst_frm_err", {31'd0, frm_err}, 32'd0);
`endif
   endtask

   initial begin
      rst        = 1'b1;
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
      sink_real  = 18'd0;
      sink_imag  = 18'd0;
      sink_size  = 6'd0;
      proc_done  = 1'b0;
      #3;
      chk_reset_outputs();
      #9;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 12-point frame, then valid samples while waiting must not be written
      frame(6'd0, 12, 1'b0);
      end_frame(12, 0);
      for (int k = 0; k < 5; k++) cyc(1'b1, k == 0, 1'b0, 6'd0, 18'($urandom), 18'($urandom));
      idle(1);
      chk("wait_no_writes", exp_q.size(), 32'd0);
      release_mem();

      // Largest frame with random valid gaps: ends at bank 4, address 239
      frame(6'd33, 1200, 1'b1);
      end_frame(1200, 33);
      release_mem();

      // Illegal size index is dropped, held frame info untouched
      cyc(1'b1, 1'b1, 1'b0, 6'd40, 18'd7, 18'd9);
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 6'd40, 18'($urandom), 18'($urandom));
      idle(2);
      chk("illegal_ready", {31'd0, sink_ready}, 32'd1);
      chk("illegal_dftpts", {20'd0, frame_dftpts}, 32'd1200);
      frame(6'd1, 24, 1'b0);
      end_frame(24, 1);
      release_mem();

      // Reset in the middle of a 300-point frame
      partial(6'd15, 100);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      chk("rst_queue", exp_q.size(), 32'd0);
      idle(2);
      rst = 1'b0;
      idle(1);
      chk("rst_no_rdy", rdy_cnt, exp_rdy);
      frame(6'd0, 12, 1'b0);
      end_frame(12, 0);
      release_mem();

`ifdef MRD_SINK_FRMCHK_EN
      // Early eop on sample 20 of a 24-point frame
      partial(6'd1, 19);
      cyc(1'b1, 1'b0, 1'b1, 6'd1, 18'd5, 18'd6);
      exp_err++;
      idle(2);
      chk("early_eop_err", err_cnt, exp_err);
      chk("early_eop_rdy", rdy_cnt, exp_rdy);
      chk("early_eop_ready", {31'd0, sink_ready}, 32'd1);
      chk("early_eop_queue", exp_q.size(), 32'd0);

      // sop at sample 10 restarts the frame at bank 0, address 0
      partial(6'd1, 10);
      exp_err++;
      frame(6'd1, 24, 1'b0);
      end_frame(24, 1);
      release_mem();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mrd_sink_wr.md
Name: mrd_sink_wr

Overview:
- Input stage of the mixed-radix DFT: accepts the streaming sample interface (valid/sop/eop/18-bit real+imag/6-bit size index).
- Writes each frame into the 5-bank data memory used by the radix-2/3/4/5 engine: sample n goes to bank n mod 5, address n div 5.
- Signals frame availability to the control FSM, then blocks new input until the engine releases the memory.

Parameters:
- DW, 18, sample component width (real and imag).
- NBANK, 5, number of memory banks; fixed by the radix-5 butterfly.
- AW, 8, bank address width (1200/5 = 240 words max).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- sink_valid  in  1  input sample valid
- sink_sop  in  1  first sample of frame
- sink_eop  in  1  last sample of frame
- sink_real  in  DW  sample real, signed
- sink_imag  in  DW  sample imag, signed
- sink_size  in  6  DFT size index 0..33 (12..1200); sampled with sop
- sink_ready  out  1  block can accept samples
- wr_en  out  1  memory write strobe
- wr_bank  out  3  bank index 0..4
- wr_addr  out  AW  address within bank
- wr_real  out  DW  write data real
- wr_imag  out  DW  write data imag
- frame_rdy  out  1  one-cycle pulse: full frame stored
- frame_dftpts  out  12  points of stored frame, held until next sop
- frame_size  out  6  size index of stored frame, held
- proc_done  in  1  engine finished with memory (pulse)

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: all outputs 0 except sink_ready=1. State returns to IDLE.
- Accept condition: sink_valid & sink_ready.
- Size table: 34-entry constant ROM, 12*M for M in {1,2,3,4,5,6,8,9,10,12,15,16,18,20,24,25,27,30,32,36,40,45,48,50,54,60,64,72,75,80,81,90,96,100}. Index >33 is an illegal size.
- IDLE:
  - sink_ready=1; samples without sop are discarded.
  - Accepted sop with legal size: latch size and dftpts, write sample 0, go FILL.
  - Accepted sop with illegal size: discard, stay IDLE.
- FILL:
  - sink_ready=1.
  - Each accepted sample increments counter n (12-bit), bank (wraps 4->0), and addr (increments when bank wraps).
  - On the sample with n == dftpts-1: go WAIT, sink_ready drops the next cycle.
- Write timing: write registered 1 cycle after accept: wr_en=1, wr_bank/wr_addr from pre-increment counters, wr_real/wr_imag = input sample.
- frame_rdy: pulses on the cycle the last write is issued (same cycle as the final wr_en).
- WAIT:
  - sink_ready=0; no writes.
  - proc_done -> IDLE, with sink_ready=1 the following cycle.
  - proc_done outside WAIT is ignored.
- Counters: n, bank and addr clear on entering FILL; no wrap beyond dftpts.
- Reset mid-frame: partial frame abandoned, no frame_rdy.
- Same-cycle sop and eop: accepted only if dftpts==1, which is impossible, so handled as a framing error (see Optional Feature).

Optional Feature:
- Macro: MRD_SINK_FRMCHK_EN.
- Defined:
  - Framing check in FILL. Error if sop is accepted in FILL, or eop is accepted with n != dftpts-1.
  - On error: the frame is dropped and no frame_rdy is issued. A one-cycle pulse is output on extra port frm_err (1 bit, reset 0).
  - A mid-frame sop restarts a new frame at n=0 in the same cycle. An early eop returns to IDLE.
  - A missing eop on the last sample is also flagged frm_err, but the frame is kept.
- Undefined:
  - sink_eop is ignored and frames end purely on count.
  - sop in FILL is treated as an ordinary sample.
  - Port frm_err is absent.

Decomposition:
- Package mrd_pkg holds:
  - constant NBANK=5;
  - the 34-entry size-to-dftpts ROM as a constant array plus a lookup function;
  - enum type for states IDLE/FILL/WAIT;
  - typedef for the 18-bit signed sample.
- One sub-module is natural: mrd_bank_addr_gen, holding the mod-5 bank / div-5 address counter pair with clear and increment inputs.

Test Plan:
- Size index 0 (12 pts), 12 consecutive valid samples with sop/eop -> writes banks 0,1,2,3,4,0,... with addresses 0,0,0,0,0,1,1,1,1,1,2,2; frame_rdy on the 12th write; sink_ready=0 afterwards.
- Size index 33 (1200 pts) with random valid gaps -> 1200 writes; last write bank 4, addr 239; frame_dftpts=1200.
- In WAIT, drive 5 valid samples then proc_done -> no writes in WAIT; sink_ready=1 one cycle after proc_done; next frame accepted.
- Size index 40 with sop -> no writes; state stays IDLE; a subsequent legal frame (index 1, 24 pts) is stored normally.
- Assert rst at sample 100 of a 300-point frame -> outputs at reset values immediately; a new 12-point frame completes with frame_rdy.
- With MRD_SINK_FRMCHK_EN, size 24 and eop on sample 20 -> frm_err pulse, no frame_rdy, sink_ready stays 1. Second case: sop at sample 10 -> frm_err, and the new frame is written starting at bank 0, addr 0.
